// File: rtl/gen_synchronizer.sv
// Generation sequencer: one render pass per frame, and on advancing frames a full
// logic round across all engines followed by a buffer swap and generation count.
module gen_synchronizer #(
  parameter int NUM_LOGIC   = 4,
  parameter int GEN_WIDTH   = 16,
  parameter int SPEED_WIDTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_LOGIC-1:0]   logic_done_in,
  input  logic                   render_done_in,
  input  logic                   buf_ready_in,
  input  logic                   run_in,
  input  logic                   step_in,
  input  logic [SPEED_WIDTH-1:0] speed_in,
  output logic [NUM_LOGIC-1:0]   logic_start_out,
  output logic                   render_start_out,
  output logic                   buf_swap_out,
  output logic [GEN_WIDTH-1:0]   generation_out,
  output logic                   busy_out
);

  typedef enum logic [1:0] {S_LAUNCH, S_WAIT, S_SWAP_WAIT, S_SWAP} state_t;

  state_t                 r_state;
  logic                   r_live;
  logic                   r_adv;
  logic                   r_step_pend;
  logic                   r_render_flag;
  logic [NUM_LOGIC-1:0]   r_logic_flags;
  logic [SPEED_WIDTH-1:0] r_frame_cnt;
  logic [GEN_WIDTH-1:0]   r_gen;

  logic [NUM_LOGIC-1:0]   w_logic_seen;
  logic                   w_render_seen;
  logic                   w_round_done;
  logic                   w_to_launch;
  logic                   w_adv_next;

  function automatic logic [SPEED_WIDTH-1:0] sat_inc(input logic [SPEED_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Exit test folds in this cycle's done inputs so a round ends without an extra idle cycle.
  always_comb begin
    w_logic_seen  = r_logic_flags | logic_done_in;
    w_render_seen = r_render_flag | render_done_in;
    w_round_done  = w_render_seen && (!r_adv || (&w_logic_seen));
    w_to_launch   = r_live && (((r_state == S_WAIT) && w_round_done && !r_adv) ||
                               (r_state == S_SWAP));
    w_adv_next    = r_step_pend || (run_in && (r_frame_cnt >= speed_in));
  end

  // r_live holds the first LAUNCH back one cycle so no pulse appears on reset release.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state       <= S_LAUNCH;
      r_live        <= 1'b0;
      r_adv         <= 1'b0;
      r_step_pend   <= 1'b0;
      r_render_flag <= 1'b0;
      r_logic_flags <= '0;
      r_frame_cnt   <= '0;
      r_gen         <= '0;
    end else begin
      r_live <= 1'b1;
      if (r_live) begin
        case (r_state)
          S_LAUNCH: begin
            r_logic_flags <= '0;
            r_render_flag <= 1'b0;
            r_state       <= S_WAIT;
          end
          S_WAIT: begin
            r_render_flag <= w_render_seen;
            if (r_adv) r_logic_flags <= w_logic_seen;
            if (w_round_done) r_state <= r_adv ? S_SWAP_WAIT : S_LAUNCH;
          end
          S_SWAP_WAIT: if (buf_ready_in) r_state <= S_SWAP;
          S_SWAP: begin
            r_gen   <= r_gen + 1'b1;
            r_state <= S_LAUNCH;
          end
          default: r_state <= S_LAUNCH;
        endcase
      end
      if (w_to_launch) begin
        r_adv <= w_adv_next;
        if (w_adv_next)  r_frame_cnt <= '0;
        else if (run_in) r_frame_cnt <= sat_inc(r_frame_cnt);
      end
      // A new step request in the consuming cycle survives the consumption.
      r_step_pend <= step_in || (r_step_pend && !(w_to_launch && w_adv_next));
    end
  end

  assign render_start_out = r_live && (r_state == S_LAUNCH);
  assign logic_start_out  = {NUM_LOGIC{r_live && (r_state == S_LAUNCH) && r_adv}};
  assign buf_swap_out     = (r_state == S_SWAP);
  assign generation_out   = r_gen;
  assign busy_out         = r_adv;

endmodule

// File: tb/tb_gen_synchronizer.sv
// Bench for gen_synchronizer: directed frame scenarios with literal checkpoints, then
// randomized traffic, all compared every cycle against a frame-level behavioural model.
module tb_gen_synchronizer;
  localparam int NL = 4;
  localparam int GW = 4;
  localparam int SW = 4;
  localparam logic [NL-1:0] ALL_ONES = '1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [NL-1:0] logic_done_in = '0;
  logic          render_done_in = 1'b0;
  logic          buf_ready_in = 1'b1;
  logic          run_in = 1'b0;
  logic          step_in = 1'b0;
  logic [SW-1:0] speed_in = '0;
  logic [NL-1:0] logic_start_out;
  logic          render_start_out;
  logic          buf_swap_out;
  logic [GW-1:0] generation_out;
  logic          busy_out;

  always #5 clk_in = ~clk_in;

  gen_synchronizer #(.NUM_LOGIC(NL), .GEN_WIDTH(GW), .SPEED_WIDTH(SW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .logic_done_in(logic_done_in),
    .render_done_in(render_done_in), .buf_ready_in(buf_ready_in), .run_in(run_in),
    .step_in(step_in), .speed_in(speed_in), .logic_start_out(logic_start_out),
    .render_start_out(render_start_out), .buf_swap_out(buf_swap_out),
    .generation_out(generation_out), .busy_out(busy_out)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: frame phase (0 launch, 1 collecting dones, 2 waiting buffer, 3 swap),
  // plus an unbounded count of run-frames since the last generation.
  int        m_ph = 0;
  bit        m_live = 0, m_adv = 0, m_step = 0, m_rdone = 0, m_tl = 0;
  bit [NL-1:0] m_ldone = '0;
  int        m_runfr = 0;
  int        m_gen = 0;

  always @(posedge clk_in) begin
    if (!rst_in) begin
      m_ph = 0; m_live = 0; m_adv = 0; m_step = 0; m_rdone = 0; m_ldone = '0;
      m_runfr = 0; m_gen = 0;
    end else begin
      m_tl = 0;
      if (m_live) begin
        if (m_ph == 0) begin
          m_ldone = '0; m_rdone = 0; m_ph = 1;
        end else if (m_ph == 1) begin
          m_rdone = m_rdone | render_done_in;
          if (m_adv) m_ldone = m_ldone | logic_done_in;
          if (m_rdone && (!m_adv || m_ldone == ALL_ONES)) begin
            if (m_adv) m_ph = 2; else m_tl = 1;
          end
        end else if (m_ph == 2) begin
          if (buf_ready_in) m_ph = 3;
        end else begin
          m_gen = (m_gen + 1) % (1 << GW);
          m_tl = 1;
        end
      end
      m_live = 1;
      if (m_tl) begin
        m_adv = m_step || (run_in && ((m_runfr > 15 ? 15 : m_runfr) >= int'(speed_in)));
        if (m_adv) begin
          m_runfr = 0;
          m_step = 0;
        end else if (run_in) m_runfr = m_runfr + 1;
        m_ph = 0;
      end
      if (step_in) m_step = 1;
    end
  end

  always @(negedge clk_in) begin
    check("render_start", 32'(render_start_out), 32'(m_live && m_ph == 0));
    check("logic_start", 32'(logic_start_out), (m_live && m_ph == 0 && m_adv) ? 32'(ALL_ONES) : 32'd0);
    check("buf_swap", 32'(buf_swap_out), 32'(m_ph == 3));
    check("generation", 32'(generation_out), 32'(m_gen));
    check("busy", 32'(busy_out), 32'(m_adv));
  end

  // Done responder: render done rdelay cycles after launch; logic dones in order 0,2,1,3.
  bit rmode = 0;
  int rdelay = 2;
  int rcnt = 0, lcnt = 0;
  always @(posedge clk_in) begin
    #2;
    if (rmode) begin
      render_done_in = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < NL; b++) logic_done_in[b] = ($urandom_range(0, 2) == 0);
    end else begin
      render_done_in = 1'b0;
      logic_done_in  = '0;
      if (!rst_in) begin
        rcnt = 0; lcnt = 0;
      end else begin
        if (render_start_out) rcnt = rdelay;
        else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) render_done_in = 1'b1;
        end
        if (logic_start_out[0]) lcnt = rdelay + 5;
        else if (lcnt > 0) begin
          lcnt--;
          case (lcnt)
            4: logic_done_in[0] = 1'b1;
            3: logic_done_in[2] = 1'b1;
            2: logic_done_in[1] = 1'b1;
            1: logic_done_in[3] = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic wait_out(input int which, input string name);
    int n = 0;
    bit hit = 0;
    while (n < 400) begin
      hit = (which == 0) ? render_start_out : (which == 1) ? (logic_start_out != '0) : buf_swap_out;
      if (hit) break;
      cyc(1);
      n++;
    end
    check({name, "_timeout"}, 32'(hit), 32'd1);
  endtask

  int nr, nl, ns, t;

  initial begin
    cyc(4);
    check("reset_gen", 32'(generation_out), 32'd0);
    check("reset_render", 32'(render_start_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    rst_in = 1'b1;
    cyc(1);
    check("first_render", 32'(render_start_out), 32'd1);
    check("first_no_logic", 32'(logic_start_out), 32'd0);

    // Paused: a 3-cycle frame, never advancing.
    nr = 0; nl = 0; ns = 0;
    for (int i = 0; i < 30; i++) begin
      nr += int'(render_start_out); nl += int'(logic_start_out != '0); ns += int'(buf_swap_out);
      cyc(1);
    end
    check("idle_renders", nr, 10);
    check("idle_logic", nl, 0);
    check("idle_swaps", ns, 0);

    // Free-run every frame; swap two cycles after the last engine (bit 3) reports.
    run_in = 1'b1;
    wait_out(1, "logic1");
    t = 0;
    while (!buf_swap_out && t < 50) begin cyc(1); t++; end
    check("swap_offset", t, 8);
    cyc(1);
    check("gen_first", 32'(generation_out), 32'd1);
    wait_out(2, "swap2");
    cyc(1);
    check("gen_second", 32'(generation_out), 32'd2);

    // One generation per three frames.
    speed_in = 2;
    wait_out(2, "swap3");
    cyc(1);
    nr = 0; nl = 0; ns = 0; t = 0;
    while (ns < 3 && t < 300) begin
      nr += int'(render_start_out); nl += int'(logic_start_out != '0); ns += int'(buf_swap_out);
      cyc(1); t++;
    end
    check("speed2_renders", nr, 9);
    check("speed2_logic", nl, 3);

    // Single-step: two pulses in one frame collapse to one generation.
    run_in = 1'b0; speed_in = 0; rdelay = 5;
    rst_in = 1'b0;
    cyc(3);
    rst_in = 1'b1;
    cyc(1);
    step_in = 1'b1; cyc(1); step_in = 1'b0; cyc(1);
    step_in = 1'b1; cyc(1); step_in = 1'b0;
    wait_out(2, "step_swap");
    cyc(30);
    check("step_single", 32'(generation_out), 32'd1);

    // A step inside the consuming launch buys a second generation.
    step_in = 1'b1; cyc(1); step_in = 1'b0;
    wait_out(1, "step_logic");
    step_in = 1'b1; cyc(1); step_in = 1'b0;
    wait_out(2, "step_swapA");
    cyc(1);
    wait_out(2, "step_swapB");
    cyc(40);
    check("step_double", 32'(generation_out), 32'd3);

    // Swap held off by the buffer controller.
    buf_ready_in = 1'b0;
    step_in = 1'b1; cyc(1); step_in = 1'b0;
    wait_out(1, "hold_logic");
    ns = 0;
    for (int i = 0; i < 30; i++) begin ns += int'(buf_swap_out); cyc(1); end
    check("hold_no_swap", ns, 0);
    check("hold_busy", 32'(busy_out), 32'd1);
    buf_ready_in = 1'b1;
    cyc(1);
    check("hold_release_swap", 32'(buf_swap_out), 32'd1);
    cyc(1);
    check("hold_gen", 32'(generation_out), 32'd4);

    // Generation counter wrap.
    rdelay = 2; run_in = 1'b1;
    t = 0;
    while (generation_out != 4'd15 && t < 2000) begin cyc(1); t++; end
    check("reach_15", 32'(generation_out), 32'd15);
    wait_out(2, "wrap_swap");
    cyc(1);
    check("wrap_zero", 32'(generation_out), 32'd0);

    // Reset in the middle of an advancing round.
    wait_out(1, "mid_logic");
    cyc(2);
    rst_in = 1'b0;
    cyc(1);
    check("midrst_gen", 32'(generation_out), 32'd0);
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_swap", 32'(buf_swap_out), 32'd0);
    cyc(1);
    rst_in = 1'b1;
    cyc(1);
    check("fresh_render", 32'(render_start_out), 32'd1);
    check("fresh_no_logic", 32'(logic_start_out), 32'd0);

    // Randomized traffic against the model.
    rmode = 1;
    for (int i = 0; i < 4000; i++) begin
      run_in       = ($urandom_range(0, 3) != 0);
      step_in      = ($urandom_range(0, 7) == 0);
      speed_in     = SW'($urandom_range(0, 3));
      buf_ready_in = ($urandom_range(0, 3) != 0);
      rst_in       = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    rmode = 0; rst_in = 1'b1; step_in = 1'b0; buf_ready_in = 1'b1;
    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
